// File: rtl/flush_logic.sv
// Flush generator: decodes the execute-stage opcode and ALU flags into a squash request for fetch/decode.
// flush/flush_kind are combinational; flush_d1 lags by one unstalled edge; optional counter under FLUSH_STATS_EN.
module flush_logic (
  output logic        flush,
  input  logic [4:0]  opcode,
  input  logic        isNotEqual,
  input  logic        isLessThan,
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  output logic        flush_d1,
  output logic [1:0]  flush_kind,
  output logic [31:0] flush_count
);

  localparam logic [1:0] KIND_NONE   = 2'd0;
  localparam logic [1:0] KIND_JUMP   = 2'd1;
  localparam logic [1:0] KIND_BRANCH = 2'd2;

  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR  = 5'b00100;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_BEX = 5'b10110;

  logic [1:0] kind;
  logic       flush_d1_q;
  logic       flush_d1_d;

  // Each opcode reads only its own flag, so an unknown unused flag cannot reach flush.
  always_comb begin
    kind = KIND_NONE;
    case (opcode)
      OP_J, OP_JAL, OP_JR: kind = KIND_JUMP;
      OP_BNE, OP_BEX:      if (isNotEqual) kind = KIND_BRANCH;
      OP_BLT:              if (isLessThan) kind = KIND_BRANCH;
      default:             kind = KIND_NONE;
    endcase
  end

  assign flush_kind = kind;
  assign flush      = (kind != KIND_NONE);

  assign flush_d1_d = stall ? flush_d1_q : flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flush_d1_q <= 1'b0;
    end else begin
      flush_d1_q <= flush_d1_d;
    end
  end

  assign flush_d1 = flush_d1_q;

`ifdef FLUSH_STATS_EN
  logic [31:0] count_q;
  logic [31:0] count_d;

  // A stalled instruction is counted only on the edge where it advances.
  always_comb begin
    count_d = count_q;
    if (flush && !stall && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign flush_count = count_q;
`else
  assign flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_flush_logic.sv
// Directed bench for flush_logic: vector table, exhaustive opcode/flag sweep, registered copy, reset and counter sequences.
module tb_flush_logic;

  logic        clock;
  logic        reset;
  logic [4:0]  opcode;
  logic        isNotEqual;
  logic        isLessThan;
  logic        stall;
  logic        flush;
  logic        flush_d1;
  logic [1:0]  flush_kind;
  logic [31:0] flush_count;

  int vectors;
  int miscompares;
  logic [31:0] exp_cnt;

  flush_logic dut (
    .flush       (flush),
    .opcode      (opcode),
    .isNotEqual  (isNotEqual),
    .isLessThan  (isLessThan),
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .flush_d1    (flush_d1),
    .flush_kind  (flush_kind),
    .flush_count (flush_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] op;
    logic       ne;
    logic       lt;
    logic       exp_flush;
    logic [1:0] exp_kind;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counter reference: saturating, only where the build implements it.
  task automatic model_edge(input logic f, input logic st);
`ifdef FLUSH_STATS_EN
    if (f && !st && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
`endif
  endtask

  task automatic apply(input string name, input logic [4:0] op, input logic ne, input logic lt,
                       input logic ef, input logic [1:0] ek);
    @(negedge clock);
    opcode = op; isNotEqual = ne; isLessThan = lt; stall = 1'b0;
    #1;
    check({name, ".flush"}, {31'd0, flush}, {31'd0, ef});
    check({name, ".kind"}, {30'd0, flush_kind}, {30'd0, ek});
    @(posedge clock);
    model_edge(ef, 1'b0);
    #1;
    check({name, ".d1"}, {31'd0, flush_d1}, {31'd0, ef});
    check({name, ".count"}, flush_count, exp_cnt);
  endtask

  function automatic logic sweep_flush(input logic [4:0] op, input logic ne, input logic lt);
    if (op == 5'd1 || op == 5'd3 || op == 5'd4) return 1'b1;
    if (op == 5'd2 || op == 5'd22) return ne;
    if (op == 5'd6) return lt;
    return 1'b0;
  endfunction

  initial begin
    int ones;
    logic ef;
    logic [1:0] ek;
    vectors = 0; miscompares = 0; exp_cnt = 32'd0; ones = 0;
    reset = 1'b0; stall = 1'b0; opcode = 5'b00001; isNotEqual = 1'b0; isLessThan = 1'b0;

    tbl[0]  = '{5'b00001, 1'b0, 1'b0, 1'b1, 2'd1};
    tbl[1]  = '{5'b00011, 1'b1, 1'b1, 1'b1, 2'd1};
    tbl[2]  = '{5'b00100, 1'b0, 1'b0, 1'b1, 2'd1};
    tbl[3]  = '{5'b00010, 1'b1, 1'b0, 1'b1, 2'd2};
    tbl[4]  = '{5'b00010, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[5]  = '{5'b00110, 1'b0, 1'b1, 1'b1, 2'd2};
    tbl[6]  = '{5'b00110, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[7]  = '{5'b10110, 1'b1, 1'b0, 1'b1, 2'd2};
    tbl[8]  = '{5'b10110, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[9]  = '{5'b00101, 1'b1, 1'b1, 1'b0, 2'd0};
    tbl[10] = '{5'b00000, 1'b1, 1'b1, 1'b0, 2'd0};
    tbl[11] = '{5'b11111, 1'b1, 1'b1, 1'b0, 2'd0};
    tbl[12] = '{5'b10010, 1'b1, 1'b0, 1'b0, 2'd0};

    // Reset state, and combinational flush alive while reset is held.
    #1;
    check("rst.d1", {31'd0, flush_d1}, 32'd0);
    check("rst.count", flush_count, 32'd0);
    check("rst.flush_comb", {31'd0, flush}, 32'd1);
    @(posedge clock); #1;
    check("rst.d1_held", {31'd0, flush_d1}, 32'd0);
    @(negedge clock);
    opcode = 5'b00000; reset = 1'b1;

    for (int i = 0; i < 13; i++)
      apply("tbl", tbl[i].op, tbl[i].ne, tbl[i].lt, tbl[i].exp_flush, tbl[i].exp_kind);

    // Exhaustive sweep over every opcode and flag pair.
    for (int op = 0; op < 32; op++) begin
      for (int f = 0; f < 4; f++) begin
        ef = sweep_flush(5'(op), f[1], f[0]);
        ek = !ef ? 2'd0 : ((op == 1 || op == 3 || op == 4) ? 2'd1 : 2'd2);
        if (ef) ones++;
        apply("sweep", 5'(op), f[1], f[0], ef, ek);
        if (flush_kind == 2'd3) begin
          miscompares++;
          $display("FAIL sweep.kind3: got 3 expected 0..2 at op %0d", op);
        end
      end
    end
    check("sweep.taken_total", ones, 32'd18);

    // Unknown values on ignored flags.
    @(negedge clock);
    opcode = 5'b00001; isNotEqual = 1'bx; isLessThan = 1'bx; #1;
    check("x.j", {31'd0, flush}, 32'd1);
    opcode = 5'b00010; isNotEqual = 1'b1; isLessThan = 1'bx; #1;
    check("x.bne", {30'd0, flush_kind}, 32'd2);
    opcode = 5'b00110; isNotEqual = 1'bx; isLessThan = 1'b0; #1;
    check("x.blt", {31'd0, flush}, 32'd0);
    opcode = 5'b00000; isNotEqual = 1'b0; isLessThan = 1'b0;
    @(posedge clock); #1;

    // Single-cycle pulse on the delayed copy.
    apply("pulse.on", 5'b00001, 1'b0, 1'b0, 1'b1, 2'd1);
    apply("pulse.off", 5'b00000, 1'b0, 1'b0, 1'b0, 2'd0);

    // Stall holds the delayed copy across two edges.
    apply("stall.set", 5'b00001, 1'b0, 1'b0, 1'b1, 2'd1);
    @(negedge clock);
    opcode = 5'b00000; stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      check("stall.hold", {31'd0, flush_d1}, 32'd1);
    end
    @(negedge clock);
    stall = 1'b0;
    @(posedge clock); #1;
    check("stall.release", {31'd0, flush_d1}, 32'd0);

    // Asynchronous reset mid-cycle drops a pending flush_d1.
    apply("arst.set", 5'b00001, 1'b0, 1'b0, 1'b1, 2'd1);
    @(negedge clock); #2;
    reset = 1'b0; #1;
    exp_cnt = 32'd0;
    check("arst.d1", {31'd0, flush_d1}, 32'd0);
    check("arst.count", flush_count, 32'd0);
    check("arst.flush_comb", {31'd0, flush}, 32'd1);
    @(posedge clock); #1;
    check("arst.d1_during", {31'd0, flush_d1}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); model_edge(1'b1, 1'b0); #1;
    check("arst.first_capture", {31'd0, flush_d1}, 32'd1);
    check("arst.first_count", flush_count, exp_cnt);

    // Counter: one stalled jal edge plus five advancing ones counts five.
    @(negedge clock);
    reset = 1'b0; exp_cnt = 32'd0; #1;
    reset = 1'b1;
    opcode = 5'b00011; stall = 1'b1;
    @(posedge clock); #1;
    check("cnt.stalled", flush_count, 32'd0);
    @(negedge clock);
    stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); model_edge(1'b1, 1'b0); #1;
    end
`ifdef FLUSH_STATS_EN
    check("cnt.five", flush_count, 32'd5);
`else
    check("cnt.five", flush_count, 32'd0);
`endif
    @(negedge clock);
    opcode = 5'b00000;

`ifdef FLUSH_STATS_EN
    // Saturation from a preloaded near-full count.
    @(negedge clock);
    dut.count_q = 32'hFFFF_FFFE; exp_cnt = 32'hFFFF_FFFE;
    opcode = 5'b00100;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); model_edge(1'b1, 1'b0); #1;
      check("cnt.sat_step", flush_count, exp_cnt);
    end
    check("cnt.saturated", flush_count, 32'hFFFF_FFFF);
    @(negedge clock);
    opcode = 5'b00000;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flush_logic.md
# flush_logic

Branch/jump resolution flush generator for the five-stage pipeline. It decodes the 5-bit opcode of the instruction in the execute stage and the ALU comparison flags to decide whether the two younger instructions (fetch and decode) must be squashed. It also provides a one-cycle-delayed flush copy and an optional flush event counter.

## Interface
- No parameters.
- `clock` input 1: pipeline clock, rising-edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `flush` output 1: combinational flush request for the current execute-stage instruction. Port order starts with `flush, opcode, isNotEqual, isLessThan`.
- `opcode` input 5: opcode of the execute-stage instruction.
- `isNotEqual` input 1: ALU flag; operands differ.
- `isLessThan` input 1: ALU flag; first operand < second operand (signed).
- `stall` input 1: pipeline stall; the execute-stage instruction is held and will be re-presented.
- `flush_d1` output 1: registered `flush`, used to squash the instruction one stage later.
- `flush_kind` output 2: 0 = none, 1 = unconditional jump, 2 = taken branch, 3 = reserved (never driven).
- `flush_count` output 32: saturating count of flush events (only with `FLUSH_STATS_EN`).

## Operation
- Opcode decode for `flush` (purely combinational; independent of `clock`, `reset`, `stall`):
  - 00001 j → 1.
  - 00011 jal → 1.
  - 00100 jr → 1.
  - 00010 bne → `isNotEqual`.
  - 00110 blt → `isLessThan`.
  - 10110 bex → `isNotEqual` (rstatus compared against $r0).
  - All other 26 opcodes → 0, regardless of the flags.
- Flag behaviour:
  - Flags are ignored for j/jal/jr.
  - `isLessThan` is ignored for bne and bex.
  - `isNotEqual` is ignored for blt.
- `flush_kind`: 1 for j/jal/jr, 2 when bne/blt/bex resolve taken, else 0. It is combinational and consistent with `flush` (`flush` = `flush_kind` != 0).
- X or Z on an unused flag must not propagate to `flush` for opcodes that ignore it.

## Timing
- `flush` and `flush_kind` have zero latency and settle within the same cycle as `opcode` and the flags.
- `flush_d1` on each rising `clock`:
  - `stall` = 0: `flush_d1` takes the value of `flush`.
  - `stall` = 1: `flush_d1` holds its value.
- Reset:
  - `reset` low asynchronously forces `flush_d1` = 0 and `flush_count` = 0 immediately, without waiting for a clock edge.
  - Release is synchronous to the next rising edge; the first capture occurs on the first edge with `reset` high.
- Reset mid-operation: a pending `flush_d1` = 1 is dropped. Combinational `flush` still follows its inputs during reset.
- Counter:
  - Increments on a rising edge when `flush` = 1, `stall` = 0 and `reset` is high.
  - A stalled instruction is counted once, on the edge where it leaves the stage.
  - Saturates at 32'hFFFF_FFFF; no wrap.

## Configuration
- `FLUSH_STATS_EN` defined:
  - `flush_count` is implemented as described above.
- `FLUSH_STATS_EN` undefined:
  - The `flush_count` port still exists and is tied to 32'h0.
  - No counter flops are synthesized.
  - All other behaviour is identical.

## Test plan
- Exhaustive combinational sweep: all 32 opcodes × 4 flag combinations (128 vectors), with `stall` = 0.
  - `flush` = 1 exactly for: {00001, 00011, 00100} with any flags; 00010 and 10110 with `isNotEqual` = 1; 00110 with `isLessThan` = 1.
  - All other 128 − (12 + 4 + 2) cases → 0.
- Flag isolation:
  - opcode 00010, `isNotEqual` = 0, `isLessThan` = 1 → `flush` = 0, `flush_kind` = 0.
  - opcode 00110, `isNotEqual` = 1, `isLessThan` = 0 → `flush` = 0.
- Registered copy:
  - Apply opcode 00001 for one cycle, then 00000 → `flush_d1` = 1 for exactly the following cycle, then 0.
  - Repeat with `stall` = 1 held over two edges → `flush_d1` holds.
- Async reset:
  - Set `flush_d1` = 1, then drop `reset` mid-cycle → `flush_d1` = 0 and `flush_count` = 0 before the next edge.
  - Release `reset` → first capture on the next edge.
- Counter (`FLUSH_STATS_EN`):
  - 5 cycles of jal with one extra stalled cycle → `flush_count` = 5.
  - Preload near 32'hFFFF_FFFE, then 3 flushes → saturates at 32'hFFFF_FFFF.
  - Without the macro → `flush_count` stays 0.
- Kind encoding:
  - jr → `flush_kind` = 1.
  - bex with `isNotEqual` = 1 → 2.
  - addi (00101) → 0.
  - 3 never appears over the full sweep.
